// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory pipeline stage and the
// data-memory responder. The memory stage holds the master modport,
// the responder holds the slave modport.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: a single-outstanding-request RV32I load/store
// memory with a programmable fixed latency. A request is accepted only
// in IDLE, waits LATENCY cycles, touches the array on the way into RESP
// and presents a one-cycle response strobe.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to turn misaligned
// halfword/word accesses into access faults instead of silently using
// the aligned lane.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic               clk,
   input  logic               reset,
   dmem_responder_if.slave    bus,
   output logic               busy
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_INIT = 4'(LATENCY);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;

   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_funct3;

   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             handshake;
   logic             do_access;
   logic             acc_we;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [2:0]       acc_funct3;
   logic [IDX_W-1:0] word_idx;
   logic [1:0]       offset;
   logic [31:0]      rd_word;
   logic [7:0]       byte_val;
   logic [15:0]      half_val;
   logic [31:0]      load_data;
   logic [3:0]       st_be;
   logic [31:0]      st_data;
   logic             bad_code;
   logic             misalign;
   logic             acc_err;
   logic             wr_en;
   logic             unused_addr_hi;

   assign handshake     = bus.req_valid & (state == IDLE);
   assign busy          = (state != IDLE);
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   // With zero latency the access happens on the handshake edge itself, so
   // the live request fields are used; otherwise the latched copy is used.
   always_comb begin
      if (state == IDLE) begin
         acc_we     = bus.req_we;
         acc_addr   = bus.req_addr;
         acc_wdata  = bus.req_wdata;
         acc_funct3 = bus.req_funct3;
      end else begin
         acc_we     = lat_we;
         acc_addr   = lat_addr;
         acc_wdata  = lat_wdata;
         acc_funct3 = lat_funct3;
      end
   end

   assign do_access = !reset &&
                      (((LATENCY == 0) && handshake) ||
                       ((state == WAIT) && (cnt == 4'd1)));

   assign word_idx       = acc_addr[IDX_W+1:2];
   assign offset         = acc_addr[1:0];
   assign unused_addr_hi = ^acc_addr[31:IDX_W+2];
   assign rd_word        = mem[word_idx];
   assign byte_val       = rd_word[{offset, 3'b000} +: 8];
   assign half_val       = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

   // Decode width code into load formatting, store lane enables and faults.
   always_comb begin
      load_data = 32'h0;
      st_be     = 4'b0000;
      st_data   = 32'h0;
      bad_code  = 1'b0;
      misalign  = 1'b0;
      if (acc_we) begin
         bad_code = (acc_funct3 > 3'b010);
      end else begin
         bad_code = (acc_funct3 == 3'b011) || (acc_funct3 == 3'b110) ||
                    (acc_funct3 == 3'b111);
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = ((acc_funct3[1:0] == 2'b01) && acc_addr[0]) ||
                 ((acc_funct3 == 3'b010) && (acc_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      case (acc_funct3)
         3'b000: load_data = {{24{byte_val[7]}}, byte_val};
         3'b100: load_data = {24'h0, byte_val};
         3'b001: load_data = {{16{half_val[15]}}, half_val};
         3'b101: load_data = {16'h0, half_val};
         3'b010: load_data = rd_word;
         default: load_data = 32'h0;
      endcase
      case (acc_funct3)
         3'b000: begin
            st_be   = 4'b0001 << offset;
            st_data = {4{acc_wdata[7:0]}};
         end
         3'b001: begin
            st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{acc_wdata[15:0]}};
         end
         3'b010: begin
            st_be   = 4'b1111;
            st_data = acc_wdata;
         end
         default: begin
            st_be   = 4'b0000;
            st_data = 32'h0;
         end
      endcase
   end

   assign acc_err = bad_code | misalign;
   assign wr_en   = do_access & acc_we & ~acc_err;

   // Capture the request on handshake so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (handshake) begin
         lat_we     <= bus.req_we;
         lat_addr   <= bus.req_addr;
         lat_wdata  <= bus.req_wdata;
         lat_funct3 <= bus.req_funct3;
      end
   end

   // Storage array; byte-lane writes, deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   // Control FSM plus response registers, which hold until the next access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  if (LATENCY == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= LAT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state <= RESP;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (do_access) begin
            rsp_rdata_q <= (acc_we || acc_err) ? 32'h0 : load_data;
            rsp_err_q   <= acc_err;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Stimulus pushes hand-computed expected responses; a negedge monitor pops
// and compares whenever rsp_valid is seen. Honors DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;

   localparam int LAT = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic busy;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          fails  = 0;
   int          cyc    = 0;
   logic        hold_en = 1'b0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;
   logic [31:0] w10;

   dmem_responder_if bus();

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every response, otherwise checks hold.
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
            check_output("rsp_err", {31'b0, bus.rsp_err}, {31'b0, mon_e.err});
            check_output("rsp_cycle", cyc, mon_e.cyc);
         end
         last_rdata = bus.rsp_rdata;
         last_err   = bus.rsp_err;
      end else if (hold_en) begin
         check_output("rdata_hold", bus.rsp_rdata, last_rdata);
         check_output("err_hold", {31'b0, bus.rsp_err}, {31'b0, last_err});
      end
   end

   task automatic apply_stimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3,
                                 input logic [31:0] exp_rdata, input logic exp_err);
      int waited = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_funct3 = f3;
      while (bus.req_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) begin
         checks++;
         fails++;
         $display("[TB] FAIL handshake_timeout: got req_ready=0 for 50 cycles, expected 1");
         bus.req_valid = 1'b0;
         return;
      end
      exp_q.push_back('{exp_rdata, exp_err, cyc + LAT + 1});
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.req_we     = ~we;
      bus.req_addr   = 32'hFFFF_FFFC;
      bus.req_wdata  = ~wdata;
      bus.req_funct3 = ~f3;
   endtask

   task automatic wait_idle();
      int waited = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) begin
         checks++;
         fails++;
         $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
      end
   endtask

   // Back-to-back loads with req_valid held high the whole time.
   task automatic stream_loads(input int n, input logic [31:0] exp);
      int got = 0;
      int prev = -1;
      int budget = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h10;
      bus.req_funct3 = 3'b010;
      while (got < n && budget < 100) begin
         if (bus.req_ready === 1'b1) begin
            exp_q.push_back('{exp, 1'b0, cyc + LAT + 1});
            if (prev >= 0) check_output("accept_spacing", cyc - prev, LAT + 2);
            prev = cyc;
            got++;
         end else begin
            check_output("busy_when_not_ready", {31'b0, busy}, 32'd1);
         end
         @(negedge clk);
         budget++;
      end
      bus.req_valid = 1'b0;
      if (got < n) begin
         checks++;
         fails++;
         $display("[TB] FAIL stream_timeout: got %0d acceptances, expected %0d", got, n);
      end
   endtask

   // Main directed sequence.
   initial begin
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.req_funct3 = 3'b000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_output("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check_output("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check_output("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      check_output("reset_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
      check_output("reset_busy", {31'b0, busy}, 32'd0);
      last_rdata = 32'h0;
      last_err   = 1'b0;
      hold_en    = 1'b1;

      apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
      apply_stimulus(1'b1, 32'h11, 32'h000000AA, 3'b000, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFFFFAA, 1'b0);
      apply_stimulus(1'b0, 32'h11, 32'h0, 3'b100, 32'h000000AA, 1'b0);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADAAEF, 1'b0);
      apply_stimulus(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0);
      apply_stimulus(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b111, 32'h0, 1'b1);
      apply_stimulus(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b100, 32'h000000EF, 1'b0);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFAAEF, 1'b0);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b101, 32'h0000AAEF, 1'b0);
      apply_stimulus(1'b1, 32'h10, 32'h01020304, 3'b011, 32'h0, 1'b1);
      apply_stimulus(1'b1, 32'h10, 32'h01020304, 3'b100, 32'h0, 1'b1);
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADAAEF, 1'b0);

      apply_stimulus(1'b1, 32'h14, 32'h11223344, 3'b010, 32'h0, 1'b0);
      apply_stimulus(1'b1, 32'h16, 32'hFFFFBEEF, 3'b001, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h14, 32'h0, 3'b010, 32'hBEEF3344, 1'b0);
      apply_stimulus(1'b1, 32'h14, 32'h12345677, 3'b000, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h14, 32'h0, 3'b010, 32'hBEEF3377, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
      apply_stimulus(1'b1, 32'h13, 32'h12345678, 3'b010, 32'h0, 1'b1);
      w10 = 32'hDEADAAEF;
      apply_stimulus(1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1);
`else
      apply_stimulus(1'b1, 32'h13, 32'h12345678, 3'b010, 32'h0, 1'b0);
      w10 = 32'h12345678;
      apply_stimulus(1'b0, 32'h11, 32'h0, 3'b001, 32'h00005678, 1'b0);
`endif
      apply_stimulus(1'b0, 32'h10, 32'h0, 3'b010, w10, 1'b0);
      wait_idle();

      stream_loads(3, w10);
      wait_idle();

      hold_en = 1'b0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h55555555;
      bus.req_funct3 = 3'b010;
      check_output("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_output("abort_ready_after", {31'b0, bus.req_ready}, 32'd1);
      check_output("abort_busy_after", {31'b0, busy}, 32'd0);
      check_output("abort_rdata_after", bus.rsp_rdata, 32'h0);
      last_rdata = 32'h0;
      last_err   = 1'b0;
      hold_en    = 1'b1;
      repeat (4) @(negedge clk);

      apply_stimulus(1'b0, 32'h1010, 32'h0, 3'b010, w10, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit storage words (power of two).
REQ-002 Parameter LATENCY, default 2, range 0..15, SHALL set the number of wait cycles between request acceptance and response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  memory-stage request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_funct3  input  3  RV32I load/store width code.
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access fault, valid with rsp_valid.
REQ-014 busy  output  1  transaction in flight; drives pipeline stall.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-016 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready.
REQ-017 On handshake, req_we, req_addr, req_wdata and req_funct3 SHALL be latched; later input changes have no effect.
REQ-018 IDLE->WAIT on handshake with a wait counter loaded to LATENCY; when LATENCY=0, IDLE->RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle; WAIT->RESP on the cycle the counter reaches 1.
REQ-020 Array access (write or read) SHALL occur only on the transition into RESP; total latency handshake->rsp_valid = LATENCY+1 cycles.
REQ-021 RESP SHALL last exactly one cycle with rsp_valid=1, then go to IDLE; there is no response back-pressure.
REQ-022 req_valid in a RESP cycle SHALL NOT be accepted; it is accepted in the following IDLE cycle.
REQ-023 Word index = addr[31:2] modulo DEPTH_WORDS (silent wrap); byte offset = addr[1:0].
REQ-024 Loads: 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW returns the full word.
REQ-025 Stores: 000 SB writes one byte lane, 001 SH two lanes, 010 SW all four; unselected lanes SHALL be unchanged.
REQ-026 Any other funct3 (loads: 011, 110, 111; stores: 011 and above) SHALL give rsp_err=1 and rsp_rdata=0, with no write.
REQ-027 rsp_rdata and rsp_err SHALL hold their values from the last RESP until the next RESP.

Reset
REQ-028 reset SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0 and rsp_err 0; req_ready is 1 on the cycle after reset.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 Reset in WAIT SHALL abandon the transaction: no write, no response.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL give rsp_err=1 and rsp_rdata=0, with no write.
REQ-032 Macro undefined: halfword accesses use lane addr[1] and ignore addr[0]; word accesses ignore addr[1:0]; rsp_err comes only from REQ-026.

Verification
REQ-033 LATENCY=2: SW addr 0x10, data 0xDEADBEEF -> rsp_valid exactly 3 cycles after the handshake, rsp_err=0; then LW 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-034 After REQ-033: SB 0x11, data 0x000000AA; then LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LW 0x10 -> 0xDEADAAEF.
REQ-035 LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD; funct3=011 load -> rsp_err=1, rsp_rdata=0.
REQ-036 With DMEM_MISALIGN_TRAP_EN: SW 0x13, data 0x12345678 -> rsp_err=1, and word 0x10 is unchanged. Without the macro: the same SW writes word 0x10, and LW 0x10 -> 0x12345678.
REQ-037 Hold req_valid high continuously -> one acceptance every LATENCY+2 cycles, and req_ready=0 in every WAIT and RESP cycle.
REQ-038 Assert reset one cycle after an SW handshake -> no rsp_valid, word unchanged, req_ready=1 on the next cycle; with DEPTH_WORDS=1024, LW 0x1010 returns word 0x10 (address wrap).
